// File: rtl/irq_sequencer_pkg.sv
// Shared constants, FSM encoding and the priority helper for the interrupt sequencer.
// Pure declarations: no latency, no backpressure.
package irq_sequencer_pkg;

   localparam logic [1:0] CFG_ENABLE  = 2'd0;
   localparam logic [1:0] CFG_PENDING = 2'd1;
   localparam logic [1:0] CFG_CAUSE   = 2'd2;
   localparam logic [1:0] CFG_STATUS  = 2'd3;

   localparam int GIE_BIT = 31;

   // Handler entry address the decoder jumps to when irq is accepted.
   localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      SERVICE = 2'd2
   } state_t;

   // Lowest set index wins; returns 0 when nothing is requested.
   function automatic logic [3:0] prio_sel(input logic [15:0] req);
      logic [3:0] sel;
      sel = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (req[i]) sel = 4'(i);
      end
      return sel;
   endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// Source lines, config bus, ID-stage qualifiers and IRQ outputs of the sequencer.
// Wiring only: no latency, no backpressure.
interface irq_sequencer_if #(
   parameter int N_SRC = 4
);
   logic [N_SRC-1:0] irq_src;
   logic             cfg_we;
   logic [1:0]       cfg_addr;
   logic [31:0]      cfg_wdata;
   logic [31:0]      cfg_rdata;
   logic             id_valid;
   logic             id_supervised;
   logic             id_jump_hazard;
   logic             id_stall;
   logic             irq;
   logic [3:0]       irq_cause;
   logic             in_service;

   modport master (
      output irq_src, cfg_we, cfg_addr, cfg_wdata,
      output id_valid, id_supervised, id_jump_hazard, id_stall,
      input  cfg_rdata, irq, irq_cause, in_service
   );

   modport slave (
      input  irq_src, cfg_we, cfg_addr, cfg_wdata,
      input  id_valid, id_supervised, id_jump_hazard, id_stall,
      output cfg_rdata, irq, irq_cause, in_service
   );
endinterface

// File: rtl/irq_sequencer_sync_edge.sv
// Per-source synchroniser chain plus rising-edge detector on the last stage.
// Latency SYNC_STAGES cycles to rise_o; no backpressure (one-cycle pulse).
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic src_i,
   output logic rise_o
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = src_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      hist_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_sequencer.sv
// Latches edge-detected sources as pending, picks the lowest enabled one and raises irq only
// in a user-mode, valid, unstalled, non-jump ID slot; a stalled or supervised slot simply holds it off.
module irq_sequencer
   import irq_sequencer_pkg::*;
#(
   parameter int N_SRC       = 4,
   parameter int SYNC_STAGES = 2
) (
   input logic            clk,
   input logic            rst_n,
   irq_sequencer_if.slave bus
);
   logic [N_SRC-1:0] rise;

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk    (clk),
         .rst_n  (rst_n),
         .src_i  (bus.irq_src[g]),
         .rise_o (rise[g])
      );
   end

   state_t           state_q, state_d;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] en_q, en_d;
   logic             gie_q, gie_d;
   logic             sup_q, sup_d;
   logic [3:0]       cause_q, cause_d;

   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] sel_oh;
   logic [3:0]       sel;
   logic             adv, safe, take;
   logic             wr_enable, wr_pending;
   logic             unused_wdata;

   assign eligible   = pend_q & en_q & {N_SRC{gie_q}};
   assign sel        = prio_sel(16'(eligible));
   assign adv        = bus.id_valid & ~bus.id_stall;
   assign safe       = adv & ~bus.id_supervised & ~bus.id_jump_hazard;
   assign take       = (state_q == ARMED) && (eligible != '0) && safe;
   assign wr_enable  = bus.cfg_we && (bus.cfg_addr == CFG_ENABLE);
   assign wr_pending = bus.cfg_we && (bus.cfg_addr == CFG_PENDING);
   assign unused_wdata = ^bus.cfg_wdata[GIE_BIT-1:N_SRC];

   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (4'(i) == sel) sel_oh[i] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      en_d    = en_q;
      gie_d   = gie_q;
      cause_d = cause_q;
      sup_d   = adv ? bus.id_supervised : sup_q;

      if (wr_enable) begin
         en_d  = bus.cfg_wdata[N_SRC-1:0];
         gie_d = bus.cfg_wdata[GIE_BIT];
      end
      if (wr_pending) pend_d = pend_d & ~bus.cfg_wdata[N_SRC-1:0];

      unique case (state_q)
         IDLE: begin
            if (eligible != '0) state_d = ARMED;
         end
         ARMED: begin
            if (eligible == '0) begin
               state_d = IDLE;
            end else if (take) begin
               pend_d  = pend_d & ~sel_oh;
               cause_d = sel;
               state_d = SERVICE;
            end
         end
         SERVICE: begin
            // Handler is done once the first advancing instruction drops back to user mode.
            if (adv && sup_q && !bus.id_supervised) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // New edges are applied last so a same-cycle set beats any clear.
      pend_d = pend_d | rise;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         en_q    <= '0;
         gie_q   <= 1'b0;
         sup_q   <= 1'b0;
         cause_q <= 4'd0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         en_q    <= en_d;
         gie_q   <= gie_d;
         sup_q   <= sup_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      bus.cfg_rdata = '0;
      unique case (bus.cfg_addr)
         CFG_ENABLE: begin
            bus.cfg_rdata[N_SRC-1:0] = en_q;
            bus.cfg_rdata[GIE_BIT]   = gie_q;
         end
         CFG_PENDING: bus.cfg_rdata[N_SRC-1:0] = pend_q;
         CFG_CAUSE:   bus.cfg_rdata[3:0]       = cause_q;
         CFG_STATUS: begin
            bus.cfg_rdata[0] = (state_q == SERVICE);
            bus.cfg_rdata[1] = (state_q == ARMED);
         end
         default: bus.cfg_rdata = '0;
      endcase
   end

   assign bus.irq        = take;
   assign bus.in_service = (state_q == SERVICE);
   assign bus.irq_cause  = (state_q == SERVICE) ? cause_q : sel;

endmodule
